// File: rtl/itams_ctrl.sv
// rtl/itams_ctrl.sv - slow/fast trajectory attractor search controller for GRN nodes
// Optional cycle-length measurement (PSTEP/PCMP, period output) is built when ITAMS_PERIOD_EN is defined.
module itams_ctrl #(
  parameter int NNOS  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NNOS-1:0]  init_vec,
  input  logic [CNT_W-1:0] max_steps,
  input  logic [NNOS-1:0]  s0_vec,
  input  logic [NNOS-1:0]  s1_vec,
  output logic             reset_nos,
  output logic [NNOS-1:0]  init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] meet_steps,
  output logic [NNOS-1:0]  attractor,
  output logic [CNT_W-1:0] period
);

`ifdef ITAMS_PERIOD_EN
  typedef enum logic [2:0] {IDLE, LOAD, STEP, CMP, PSTEP, PCMP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, STEP, CMP, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             reset_nos_q, reset_nos_d;
  logic [NNOS-1:0]  init_state_q, init_state_d;
  logic             start_s0_q, start_s0_d;
  logic             start_s1_q, start_s1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] meet_steps_q, meet_steps_d;
  logic [NNOS-1:0]  attractor_q, attractor_d;
`ifdef ITAMS_PERIOD_EN
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
`endif

  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    step_cnt_d   = step_cnt_q;
    timeout_d    = timeout_q;
    meet_steps_d = meet_steps_q;
    attractor_d  = attractor_q;
    init_state_d = '0;
`ifdef ITAMS_PERIOD_EN
    period_cnt_d = period_cnt_q;
    period_d     = period_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD;
          max_d        = max_steps;
          init_state_d = init_vec;
          step_cnt_d   = '0;
          timeout_d    = 1'b0;
          meet_steps_d = '0;
          attractor_d  = '0;
`ifdef ITAMS_PERIOD_EN
          period_cnt_d = '0;
          period_d     = '0;
`endif
        end
      end
      LOAD: state_d = STEP;
      STEP: begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
        state_d    = CMP;
      end
      CMP: begin
        // After step 1 both trajectories sit on f(x0), so that equality is not a meet.
        if (step_cnt_q >= CNT_W'(2) && s0_vec == s1_vec) begin
          meet_steps_d = step_cnt_q;
          attractor_d  = s0_vec;
`ifdef ITAMS_PERIOD_EN
          state_d      = PSTEP;
`else
          state_d      = DONE;
`endif
        end else if (step_cnt_q >= max_q) begin
          timeout_d    = 1'b1;
          meet_steps_d = step_cnt_q;
          state_d      = DONE;
        end else begin
          state_d = STEP;
        end
      end
`ifdef ITAMS_PERIOD_EN
      PSTEP: begin
        period_cnt_d = period_cnt_q + CNT_W'(1);
        state_d      = PCMP;
      end
      PCMP: begin
        if (s1_vec == attractor_q) begin
          period_d = period_cnt_q;
          state_d  = DONE;
        end else if (period_cnt_q >= max_q) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = PSTEP;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Strobes and status are registered from the next state so they align with it.
    reset_nos_d = (state_d == LOAD);
    start_s0_d  = (state_d == STEP);
`ifdef ITAMS_PERIOD_EN
    start_s1_d  = (state_d == STEP) || (state_d == PSTEP);
`else
    start_s1_d  = (state_d == STEP);
`endif
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      max_q        <= '0;
      step_cnt_q   <= '0;
      reset_nos_q  <= 1'b0;
      init_state_q <= '0;
      start_s0_q   <= 1'b0;
      start_s1_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      meet_steps_q <= '0;
      attractor_q  <= '0;
`ifdef ITAMS_PERIOD_EN
      period_cnt_q <= '0;
      period_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      max_q        <= max_d;
      step_cnt_q   <= step_cnt_d;
      reset_nos_q  <= reset_nos_d;
      init_state_q <= init_state_d;
      start_s0_q   <= start_s0_d;
      start_s1_q   <= start_s1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      meet_steps_q <= meet_steps_d;
      attractor_q  <= attractor_d;
`ifdef ITAMS_PERIOD_EN
      period_cnt_q <= period_cnt_d;
      period_q     <= period_d;
`endif
    end
  end

  assign reset_nos  = reset_nos_q;
  assign init_state = init_state_q;
  assign start_s0   = start_s0_q;
  assign start_s1   = start_s1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign meet_steps = meet_steps_q;
  assign attractor  = attractor_q;
`ifdef ITAMS_PERIOD_EN
  assign period     = period_q;
`else
  assign period     = '0;
`endif

endmodule

// File: tb/tb_itams_ctrl.sv
// tb/tb_itams_ctrl.sv - bench for itams_ctrl with a 4-node lookup-table network
// Period expectations follow ITAMS_PERIOD_EN when the bench is built with it.
module tb_itams_ctrl;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  init_vec, s0_vec, s1_vec, init_state, attractor;
  logic [15:0] max_steps, meet_steps, period;
  logic        reset_nos, start_s0, start_s1, busy, done, timeout;

  int errors = 0;
  int checks = 0;
  int rn_total = 0;
  int bad_strobe = 0;
  logic [3:0] fmap [16];
  logic       s0_par;

  itams_ctrl #(.NNOS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .init_vec(init_vec), .max_steps(max_steps),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1), .busy(busy), .done(done), .timeout(timeout),
    .meet_steps(meet_steps), .attractor(attractor), .period(period)
  );

  always #5 clk = ~clk;

  // Node network: s1 steps on every start_s1, s0 only on every other start_s0.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      s0_par <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= fmap[s1_vec];
      if (start_s0) begin
        if (!s0_par) s0_vec <= fmap[s0_vec];
        s0_par <= ~s0_par;
      end
    end
  end

  always @(posedge clk) begin
    if (reset_nos) rn_total++;
    if ((reset_nos && (start_s0 || start_s1)) || (start_s0 && !start_s1)) bad_strobe++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] fpow(input logic [3:0] x, input int k);
    logic [3:0] y;
    y = x;
    for (int i = 0; i < k; i++) y = fmap[y];
    return y;
  endfunction

  // Reference: first n>=2 with f^ceil(n/2)(x0)==f^n(x0), else timeout at n>=budget.
  task automatic model(input logic [3:0] x0, input int ms, output logic to, output int mst,
                       output logic [3:0] att, output int per);
    logic met;
    to = 1'b0; mst = 0; att = 4'h0; per = 0; met = 1'b0;
    for (int n = 1; n <= 70000 && !met && !to; n++) begin
      if (n >= 2 && fpow(x0, (n + 1) / 2) == fpow(x0, n)) begin
        met = 1'b1; mst = n; att = fpow(x0, n);
      end else if (n >= ms) begin
        to = 1'b1; mst = n;
      end
    end
`ifdef ITAMS_PERIOD_EN
    if (met) begin
      for (int p = 1; p <= 70000 && per == 0 && !to; p++) begin
        if (fpow(att, p) == att) per = p;
        else if (p >= ms) to = 1'b1;
      end
    end
`endif
  endtask

  task automatic set_net(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       fmap[i] = 4'(i);
        1:       fmap[i] = 4'(i + 1);
        default: fmap[i] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  task automatic run(input string tag, input logic [3:0] iv, input logic [15:0] ms, input bit poke);
    logic to_e; int ms_e; logic [3:0] att_e; int per_e; int cyc; int rn0;
    model(iv, int'(ms), to_e, ms_e, att_e, per_e);
    @(negedge clk);
    rn0 = rn_total;
    init_vec = iv; max_steps = ms; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (poke && busy && (cyc == 1 || cyc == 7)) begin
        start = 1'b1; init_vec = ~iv; max_steps = 16'd1;
      end else begin
        start = 1'b0; init_vec = iv; max_steps = ms;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, to_e);
    check({tag, "_meet_steps"}, meet_steps, ms_e);
    check({tag, "_attractor"}, attractor, att_e);
    check({tag, "_period"}, period, per_e);
    check({tag, "_reset_nos_count"}, rn_total - rn0, 1);
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b1; start = 1'b1; init_vec = 4'hF; max_steps = 16'd5;
    set_net(0);
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {reset_nos, start_s0, start_s1}, 0);
    check("rst_outputs", {timeout, meet_steps, attractor, period, init_state}, 0);

    set_net(0);
    run("identity", 4'b1010, 16'd100, 1'b0);
    check("identity_meet_const", meet_steps, 2);
    repeat (3) @(negedge clk);
    check("done_held", done, 1);

    set_net(1);
    run("inc100", 4'h0, 16'd100, 1'b0);
    check("inc100_meet_const", meet_steps, 32);
`ifdef ITAMS_PERIOD_EN
    check("inc100_period_const", period, 16);
`else
    check("inc100_period_const", period, 0);
`endif
    run("inc10", 4'h0, 16'd10, 1'b0);
    check("inc10_meet_const", {timeout, meet_steps}, {1'b1, 16'd10});
    run("inc_max0", 4'h3, 16'd0, 1'b0);
    run("inc_max1", 4'h3, 16'd1, 1'b0);
    run("inc_max32", 4'h0, 16'd32, 1'b0);
    run("inc_poke", 4'h0, 16'd100, 1'b1);

    // Reset in the middle of a search.
    @(negedge clk);
    init_vec = 4'h0; max_steps = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!start_s0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midrst_saw_step", start_s0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_outputs", {done, timeout, reset_nos, start_s0, start_s1, meet_steps, attractor, period, init_state}, 0);
    run("after_rst", 4'h0, 16'd100, 1'b0);

    for (int r = 0; r < 10; r++) begin
      set_net(2);
      run($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 40)), r[0]);
    end

    check("strobe_overlap", bad_strobe, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/itams_ctrl.md
ITAMS_CTRL -- requirements
Module: itams_ctrl

Interface
REQ-001 Parameter NNOS, default 8: number of GRN nodes driven and observed.
REQ-002 Parameter CNT_W, default 16: width of step and period counters.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin an attractor search; ignored while busy=1.
REQ-006 init_vec  input  NNOS  initial network state; sampled on the accepted start.
REQ-007 max_steps  input  CNT_W  step budget; sampled on the accepted start.
REQ-008 s0_vec  input  NNOS  concatenated slow-trajectory node states (itams_s0 of node i on bit i).
REQ-009 s1_vec  input  NNOS  concatenated fast-trajectory node states (itams_s1 of node i on bit i).
REQ-010 reset_nos  output  1  node load strobe.
REQ-011 init_state  output  NNOS  per-node load value; bit i to node i.
REQ-012 start_s0 / start_s1  output  1 each  node step strobes.
REQ-013 busy  output  1  search in progress.
REQ-014 done  output  1  result valid; held until the next accepted start.
REQ-015 timeout  output  1  budget exhausted without meet; valid when done=1.
REQ-016 meet_steps  output  CNT_W  step index at which s0_vec==s1_vec was detected, or step count at timeout.
REQ-017 attractor  output  NNOS  s0_vec captured at meet.
REQ-018 period  output  CNT_W  attractor cycle length (see Configuration).

Function
REQ-019 FSM states: IDLE, LOAD, STEP, CMP, PSTEP, PCMP, DONE.
REQ-020 IDLE: on start=1, register init_vec/max_steps, clear counters, clear done/timeout, go LOAD; busy=1 in every state except IDLE and DONE.
REQ-021 LOAD: reset_nos=1 and init_state=registered init_vec for exactly one cycle; go STEP.
REQ-022 STEP: start_s0=1 and start_s1=1 for one cycle, step_cnt incremented; go CMP.
REQ-023 Node semantics: s1 advances every step, s0 advances on steps 1,3,5,...; after step n, s0=f^ceil(n/2)(x0), s1=f^n(x0).
REQ-024 CMP: meet only when step_cnt>=2 and s0_vec==s1_vec; the step-1 equality is never a meet.
REQ-025 CMP on meet: meet_steps<=step_cnt, attractor<=s0_vec, go PSTEP (macro defined) or DONE.
REQ-026 CMP without meet: if step_cnt>=max_steps then timeout<=1, meet_steps<=step_cnt, go DONE; else go STEP.
REQ-027 max_steps of 0 or 1 times out after step 1 compare.
REQ-028 Meet and budget exhaustion on the same compare: meet wins, timeout=0.
REQ-029 PSTEP: start_s1=1 only (start_s0=0), period_cnt incremented; go PCMP.
REQ-030 PCMP: if s1_vec==attractor then period<=period_cnt, go DONE; else if period_cnt>=max_steps then timeout<=1, go DONE; else go PSTEP.
REQ-031 DONE: done=1, busy=0, all strobes 0; accepting start returns to LOAD path as in IDLE.
REQ-032 Strobes reset_nos/start_s0/start_s1 never asserted together; all are 0 outside their states.
REQ-033 Counters do not wrap: bounded by max_steps <= 2^CNT_W-1.

Reset
REQ-034 rst=1 forces IDLE next cycle from any state, including mid-search.
REQ-035 Reset values: reset_nos=0, init_state=0, start_s0=0, start_s1=0, busy=0, done=0, timeout=0, meet_steps=0, attractor=0, period=0, all internal counters 0.
REQ-036 start coincident with rst is discarded.

Configuration
REQ-037 Macro ITAMS_PERIOD_EN: when defined, PSTEP/PCMP are built and period is measured per REQ-029/030.
REQ-038 When undefined, PSTEP/PCMP are absent, CMP meet goes directly to DONE, period is tied to 0; all other behaviour identical.

Verification (NNOS=4, CNT_W=16, bench instantiates 4 nodes with equation network)
REQ-039 Identity network (f(x)=x), init_vec=4'b1010, max_steps=100 -> done, timeout=0, meet_steps=2, attractor=4'b1010, period=1 (macro on).
REQ-040 Mod-16 incrementer, init_vec=0, max_steps=100 -> meet_steps=32, attractor=4'h0, period=16; macro off -> period=0, meet_steps=32.
REQ-041 Mod-16 incrementer, init_vec=0, max_steps=10 -> done, timeout=1, meet_steps=10.
REQ-042 rst pulsed during STEP of incrementer run -> next cycle IDLE, all outputs at reset values; new start completes normally.
REQ-043 start pulsed while busy=1 -> ignored, result identical to undisturbed run; reset_nos seen exactly once per accepted start.
